keypad_frontend: RTL and testbench

Input conditioning stage placed directly upstream of the microwave `controler`. It synchronises and debounces the raw 10-key digit keypad, the `startn`/`stopn` buttons and the door switch. It emits one single-cycle one-hot strobe per accepted key press, plus a BCD digit. Its outputs drive the controller's `keypad`, `startn`, `stopn` and `door_closed` inputs, so the controller never sees bounce, multi-key chords or auto-repeat.

---
 rtl/keypad_pkg.sv | 36 +++
 rtl/debounce_bit.sv | 44 ++++
 rtl/keypad_frontend.sv | 173 +++++++++++++++++
 tb/tb_keypad_frontend.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types, sizes and helpers for the keypad input-conditioning front end.
// Latency: n/a (declarations only).
// Backpressure: n/a (no flow control in this block; inputs are sampled every cycle).
package keypad_pkg;

    localparam int NUM_KEYS    = 10;
    localparam int SYNC_STAGES = 2;
    localparam int CNT_W       = 8;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_HELD         = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } kp_state_e;

    // One-hot key vector to BCD digit. Only meaningful for one-hot input.
    function automatic logic [3:0] encode_bcd(input logic [NUM_KEYS-1:0] oh);
        logic [3:0] res;
        res = 4'd0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (oh[i]) res = 4'(i);
        end
        return res;
    endfunction

    function automatic logic is_one_hot(input logic [NUM_KEYS-1:0] v);
        return (v != '0) && ((v & (v - NUM_KEYS'(1))) == '0);
    endfunction

    // Counters stick at all-ones rather than wrapping back to zero.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == '1) ? c : c + CNT_W'(1);
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// Two-flop synchroniser plus level debouncer for one raw button/switch.
// Latency: raw change first sampled at edge N shows on level after edge N+1+DEBOUNCE_CYCLES.
// Backpressure: none; free-running every cycle.
// Ports: clk, clear (sync active-high), raw (async input), level (debounced output).
module debounce_bit
    import keypad_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = 4,
    parameter logic RESET_VAL       = 1'b0
) (
    input  logic clk,
    input  logic clear,
    input  logic raw,
    output logic level
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(DEBOUNCE_CYCLES);

    logic [SYNC_STAGES-1:0] sync;
    logic [CNT_W-1:0]       cnt;
    logic                   s;

    assign s = sync[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (clear) begin
            sync  <= {SYNC_STAGES{RESET_VAL}};
            cnt   <= '0;
            level <= RESET_VAL;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], raw};
            // Any sample agreeing with the current level restarts the run.
            if (s == level) begin
                cnt <= '0;
            end else if (sat_inc(cnt) >= LIMIT) begin
                level <= s;
                cnt   <= '0;
            end else begin
                cnt <= sat_inc(cnt);
            end
        end
    end

endmodule

// File: rtl/keypad_frontend.sv
// Synchronises/debounces the digit keypad, start/stop buttons and door switch.
// Latency: input stable from sampling edge N appears after edge N+1+DEBOUNCE_CYCLES.
// Backpressure: none; one single-cycle strobe per accepted press, no auto-repeat.
// Ports: clk, clear (sync active-high); keypad_raw[9:0], startn_raw, stopn_raw,
//        door_closed_raw in; keypad[9:0] strobe, digit[3:0], digit_valid,
//        startn, stopn, door_closed out.
module keypad_frontend
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                clk,
    input  logic                clear,
    input  logic [NUM_KEYS-1:0] keypad_raw,
    input  logic                startn_raw,
    input  logic                stopn_raw,
    input  logic                door_closed_raw,
    output logic [NUM_KEYS-1:0] keypad,
    output logic [3:0]          digit,
    output logic                digit_valid,
    output logic                startn,
    output logic                stopn,
    output logic                door_closed
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(DEBOUNCE_CYCLES);

    // Keypad synchroniser
    logic [NUM_KEYS-1:0] ks_pipe [SYNC_STAGES];
    logic [NUM_KEYS-1:0] ks;

    assign ks = ks_pipe[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (clear) begin
            for (int i = 0; i < SYNC_STAGES; i++) ks_pipe[i] <= '0;
        end else begin
            ks_pipe[0] <= keypad_raw;
            for (int i = 1; i < SYNC_STAGES; i++) ks_pipe[i] <= ks_pipe[i-1];
        end
    end

    // Keypad FSM
    kp_state_e           state, state_nxt;
    logic [NUM_KEYS-1:0] cand, cand_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt, cnt_inc;
    logic                strobe;

    always_comb begin
        state_nxt = state;
        cand_nxt  = cand;
        cnt_nxt   = cnt;
        strobe    = 1'b0;
        cnt_inc   = sat_inc(cnt);
        case (state)
            ST_IDLE: begin
                if (ks != '0) begin
                    if (is_one_hot(ks)) begin
                        cand_nxt = ks;
                        // The first sample already counts as one; with a
                        // single-cycle debounce it is accepted immediately.
                        if (LIMIT <= CNT_W'(1)) begin
                            strobe    = 1'b1;
                            cnt_nxt   = '0;
                            state_nxt = ST_HELD;
                        end else begin
                            cnt_nxt   = CNT_W'(1);
                            state_nxt = ST_PRESS_WAIT;
                        end
                    end else begin
                        // Chord: swallow it until everything is released.
                        cnt_nxt   = '0;
                        state_nxt = ST_HELD;
                    end
                end
            end
            ST_PRESS_WAIT: begin
                if (ks == '0) begin
                    cnt_nxt   = '0;
                    state_nxt = ST_IDLE;
                end else if (ks == cand) begin
                    if (cnt_inc >= LIMIT) begin
                        strobe    = 1'b1;
                        cnt_nxt   = '0;
                        state_nxt = ST_HELD;
                    end else begin
                        cnt_nxt = cnt_inc;
                    end
                end else if (is_one_hot(ks)) begin
                    cand_nxt = ks;
                    cnt_nxt  = CNT_W'(1);
                end else begin
                    cnt_nxt   = '0;
                    state_nxt = ST_HELD;
                end
            end
            ST_HELD: begin
                if (ks == '0) begin
                    if (LIMIT <= CNT_W'(1)) begin
                        cnt_nxt   = '0;
                        state_nxt = ST_IDLE;
                    end else begin
                        cnt_nxt   = CNT_W'(1);
                        state_nxt = ST_RELEASE_WAIT;
                    end
                end
            end
            ST_RELEASE_WAIT: begin
                if (ks != '0) begin
                    cnt_nxt   = '0;
                    state_nxt = ST_HELD;
                end else if (cnt_inc >= LIMIT) begin
                    cnt_nxt   = '0;
                    state_nxt = ST_IDLE;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            default: begin
                cnt_nxt   = '0;
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state <= ST_IDLE;
            cand  <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cand  <= cand_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Strobe outputs: cand_nxt holds the accepted key in every strobe case.
    always_ff @(posedge clk) begin
        if (clear) begin
            keypad      <= '0;
            digit       <= '0;
            digit_valid <= 1'b0;
        end else begin
            keypad      <= strobe ? cand_nxt : '0;
            digit_valid <= strobe;
            if (strobe) digit <= encode_bcd(cand_nxt);
        end
    end

    // Button and door debouncers
    debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RESET_VAL(1'b1)) u_startn (
        .clk   (clk),
        .clear (clear),
        .raw   (startn_raw),
        .level (startn)
    );

    debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RESET_VAL(1'b1)) u_stopn (
        .clk   (clk),
        .clear (clear),
        .raw   (stopn_raw),
        .level (stopn)
    );

    debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RESET_VAL(1'b0)) u_door_closed (
        .clk   (clk),
        .clear (clear),
        .raw   (door_closed_raw),
        .level (door_closed)
    );

endmodule

// File: tb/tb_keypad_frontend.sv
// Directed bench for keypad_frontend: a DEBOUNCE_CYCLES=4 instance and a
// DEBOUNCE_CYCLES=1 instance share the same stimulus.
// Expected values are hand-derived from the latency N+1+DEBOUNCE_CYCLES.
module tb_keypad_frontend;

    logic       clk = 1'b0;
    logic       clear;
    logic [9:0] keypad_raw;
    logic       startn_raw, stopn_raw, door_closed_raw;

    logic [9:0] keypad, keypad_b;
    logic [3:0] digit, digit_b;
    logic       digit_valid, digit_valid_b;
    logic       startn, startn_b, stopn, stopn_b, door_closed, door_closed_b;

    int checks = 0;
    int errors = 0;

    // Monitor state, updated by run()
    int         strobes_a, strobes_b, first_a, door_at, bad_valid;
    logic [9:0] last_key_a;
    logic [3:0] last_digit_a;

    always #5 clk = ~clk;

    keypad_frontend #(.DEBOUNCE_CYCLES(4)) u_dut (
        .clk             (clk),
        .clear           (clear),
        .keypad_raw      (keypad_raw),
        .startn_raw      (startn_raw),
        .stopn_raw       (stopn_raw),
        .door_closed_raw (door_closed_raw),
        .keypad          (keypad),
        .digit           (digit),
        .digit_valid     (digit_valid),
        .startn          (startn),
        .stopn           (stopn),
        .door_closed     (door_closed)
    );

    keypad_frontend #(.DEBOUNCE_CYCLES(1)) u_dut_b (
        .clk             (clk),
        .clear           (clear),
        .keypad_raw      (keypad_raw),
        .startn_raw      (startn_raw),
        .stopn_raw       (stopn_raw),
        .door_closed_raw (door_closed_raw),
        .keypad          (keypad_b),
        .digit           (digit_b),
        .digit_valid     (digit_valid_b),
        .startn          (startn_b),
        .stopn           (stopn_b),
        .door_closed     (door_closed_b)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_stats;
        strobes_a    = 0;
        strobes_b    = 0;
        first_a      = -1;
        door_at      = -1;
        last_key_a   = '0;
        last_digit_a = '0;
    endtask

    // Advance n cycles; tick 1 is the first edge that samples new inputs.
    task automatic run(input int n);
        for (int i = 1; i <= n; i++) begin
            tick();
            if (keypad != 10'h000) begin
                strobes_a++;
                if (first_a < 0) first_a = i;
                last_key_a   = keypad;
                last_digit_a = digit;
            end
            if (keypad_b != 10'h000) strobes_b++;
            if (door_closed && door_at < 0) door_at = i;
            if (digit_valid !== (keypad != 10'h000)) bad_valid++;
        end
    endtask

    task automatic test_reset;
        clear           = 1'b1;
        keypad_raw      = '0;
        startn_raw      = 1'b1;
        stopn_raw       = 1'b1;
        door_closed_raw = 1'b0;
        bad_valid       = 0;
        clear_stats();
        for (int i = 0; i < 3; i++) tick();
        checks++; if (keypad !== 10'h000) begin errors++; $display("FAIL reset_keypad: got %h want 000", keypad); end
        checks++; if (digit !== 4'd0) begin errors++; $display("FAIL reset_digit: got %0d want 0", digit); end
        checks++; if (digit_valid !== 1'b0) begin errors++; $display("FAIL reset_digit_valid: got %b want 0", digit_valid); end
        checks++; if (startn !== 1'b1) begin errors++; $display("FAIL reset_startn: got %b want 1", startn); end
        checks++; if (stopn !== 1'b1) begin errors++; $display("FAIL reset_stopn: got %b want 1", stopn); end
        checks++; if (door_closed !== 1'b0) begin errors++; $display("FAIL reset_door: got %b want 0", door_closed); end
    endtask

    task automatic test_single_press;
        clear = 1'b1;
        tick();
        clear      = 1'b0;
        keypad_raw = 10'h004;
        clear_stats();
        run(110);
        checks++; if (strobes_a != 1) begin errors++; $display("FAIL single_count: got %0d want 1", strobes_a); end
        checks++; if (first_a != 6) begin errors++; $display("FAIL single_latency: got tick %0d want 6", first_a); end
        checks++; if (last_key_a !== 10'h004) begin errors++; $display("FAIL single_key: got %h want 004", last_key_a); end
        checks++; if (last_digit_a !== 4'd2) begin errors++; $display("FAIL single_digit: got %0d want 2", last_digit_a); end
        keypad_raw = '0;
        run(10);
        checks++; if (digit !== 4'd2) begin errors++; $display("FAIL digit_hold: got %0d want 2", digit); end
        checks++; if (digit_valid !== 1'b0) begin errors++; $display("FAIL valid_idle: got %b want 0", digit_valid); end
    endtask

    task automatic test_bounce;
        clear_stats();
        for (int p = 0; p < 3; p++) begin
            keypad_raw = 10'h020; run(2);
            keypad_raw = 10'h000; run(2);
        end
        checks++; if (strobes_a != 0) begin errors++; $display("FAIL bounce_quiet: got %0d strobes want 0", strobes_a); end
        clear_stats();
        keypad_raw = 10'h020;
        run(30);
        checks++; if (strobes_a != 1) begin errors++; $display("FAIL bounce_count: got %0d want 1", strobes_a); end
        checks++; if (first_a != 6) begin errors++; $display("FAIL bounce_latency: got tick %0d want 6", first_a); end
        checks++; if (last_digit_a !== 4'd5) begin errors++; $display("FAIL bounce_digit: got %0d want 5", last_digit_a); end
        keypad_raw = '0;
        run(10);
    endtask

    task automatic test_sequence;
        int digits [3] = '{2, 5, 9};
        logic [9:0] k;
        for (int j = 0; j < 3; j++) begin
            clear_stats();
            k          = 10'b1 << digits[j];
            keypad_raw = k;
            run(20);
            checks++; if (strobes_a != 1) begin errors++; $display("FAIL seq_count[%0d]: got %0d want 1", j, strobes_a); end
            checks++; if (last_digit_a !== 4'(digits[j])) begin errors++; $display("FAIL seq_digit[%0d]: got %0d want %0d", j, last_digit_a, digits[j]); end
            keypad_raw = '0;
            run(10);
        end
    endtask

    task automatic test_chord;
        clear_stats();
        keypad_raw = 10'h024;
        run(50);
        checks++; if (strobes_a != 0) begin errors++; $display("FAIL chord_quiet: got %0d strobes want 0", strobes_a); end
        keypad_raw = '0;
        run(10);
        clear_stats();
        keypad_raw = 10'h200;
        run(20);
        checks++; if (strobes_a != 1) begin errors++; $display("FAIL after_chord_count: got %0d want 1", strobes_a); end
        checks++; if (last_digit_a !== 4'd9) begin errors++; $display("FAIL after_chord_digit: got %0d want 9", last_digit_a); end
        keypad_raw = '0;
        run(10);
    endtask

    task automatic test_no_repeat;
        clear_stats();
        keypad_raw = 10'h008; run(20);
        keypad_raw = 10'h000; run(2);
        keypad_raw = 10'h008; run(50);
        checks++; if (strobes_a != 1) begin errors++; $display("FAIL repress_d4: got %0d strobes want 1", strobes_a); end
        checks++; if (last_digit_a !== 4'd3) begin errors++; $display("FAIL repress_digit: got %0d want 3", last_digit_a); end
        checks++; if (strobes_b != 2) begin errors++; $display("FAIL repress_d1: got %0d strobes want 2", strobes_b); end
        keypad_raw = '0;
        run(10);
    endtask

    task automatic test_buttons;
        int glitches = 0;
        int fall_s = -1, fall_p = -1, rise_s = -1;
        startn_raw = 1'b0;
        tick();
        if (startn !== 1'b1) glitches++;
        startn_raw = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (startn !== 1'b1) glitches++;
        end
        checks++; if (glitches != 0) begin errors++; $display("FAIL start_glitch: %0d low cycles want 0", glitches); end

        startn_raw = 1'b0;
        stopn_raw  = 1'b0;
        for (int i = 1; i <= 100; i++) begin
            tick();
            if (startn === 1'b0 && fall_s < 0) fall_s = i;
            if (stopn === 1'b0 && fall_p < 0) fall_p = i;
        end
        checks++; if (fall_s != 6) begin errors++; $display("FAIL startn_fall: got tick %0d want 6", fall_s); end
        checks++; if (fall_p != 6) begin errors++; $display("FAIL stopn_fall: got tick %0d want 6", fall_p); end
        checks++; if (startn !== 1'b0) begin errors++; $display("FAIL startn_held: got %b want 0", startn); end

        startn_raw = 1'b1;
        stopn_raw  = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (startn === 1'b1 && rise_s < 0) rise_s = i;
        end
        checks++; if (rise_s != 6) begin errors++; $display("FAIL startn_rise: got tick %0d want 6", rise_s); end

        // Door closes in the same cycle a key goes down: both land together.
        clear_stats();
        door_closed_raw = 1'b1;
        keypad_raw      = 10'h010;
        run(20);
        checks++; if (door_at != 6) begin errors++; $display("FAIL door_rise: got tick %0d want 6", door_at); end
        checks++; if (first_a != 6) begin errors++; $display("FAIL simul_key: got tick %0d want 6", first_a); end
        checks++; if (last_digit_a !== 4'd4) begin errors++; $display("FAIL simul_digit: got %0d want 4", last_digit_a); end
        keypad_raw = '0;
        run(10);
    endtask

    task automatic test_clear_mid_press;
        clear_stats();
        keypad_raw = 10'h002;
        run(4);   // FSM is now at count 2 of PRESS_WAIT
        checks++; if (strobes_a != 0) begin errors++; $display("FAIL pre_clear: got %0d strobes want 0", strobes_a); end
        clear = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({keypad, digit, digit_valid, startn, stopn, door_closed} !== {10'h000, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL during_clear[%0d]: got kp=%h dg=%0d dv=%b st=%b sp=%b dc=%b want 000/0/0/1/1/0",
                         i, keypad, digit, digit_valid, startn, stopn, door_closed);
            end
        end
        clear = 1'b0;
        clear_stats();
        run(20);
        checks++; if (strobes_a != 1) begin errors++; $display("FAIL post_clear_count: got %0d want 1", strobes_a); end
        checks++; if (first_a != 6) begin errors++; $display("FAIL post_clear_latency: got tick %0d want 6", first_a); end
        checks++; if (last_digit_a !== 4'd1) begin errors++; $display("FAIL post_clear_digit: got %0d want 1", last_digit_a); end
        checks++; if (door_at != 6) begin errors++; $display("FAIL post_clear_door: got tick %0d want 6", door_at); end
        keypad_raw = '0;
        run(10);
    endtask

    task automatic test_valid_alignment;
        checks++; if (bad_valid != 0) begin errors++; $display("FAIL valid_align: %0d cycles where digit_valid != (keypad!=0), want 0", bad_valid); end
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_bounce();
        test_sequence();
        test_chord();
        test_no_repeat();
        test_buttons();
        test_clear_mid_press();
        test_valid_alignment();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
